// File: rtl/gcc_track_buf.sv
// Centroid tracking buffer: captures (Xc,Yc) and signed movement deltas while the
// upstream calculator holds READY_ low, and drains them through a FWFT FIFO.
module gcc_track_buf #(
    parameter int DEPTH       = 8,
    parameter bit CHANGE_ONLY = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET_,
    input  logic       READY_,
    input  logic [7:0] Xc,
    input  logic [7:0] Yc,
    input  logic       FLUSH,
    input  logic       OUT_READY,
    output logic       OUT_VALID,
    output logic [7:0] OUT_X,
    output logic [7:0] OUT_Y,
    output logic [8:0] OUT_DX,
    output logic [8:0] OUT_DY,
    output logic [4:0] COUNT,
    output logic       FULL,
    output logic       EMPTY,
    output logic [7:0] OVF_CNT,
    output logic       o_dbg_state
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_first;
    logic [7:0]      r_prev_x;
    logic [7:0]      r_prev_y;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [4:0]      r_count;
    logic [7:0]      r_ovf_cnt;
    logic [33:0]     r_mem [DEPTH];

    logic            w_capture;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [8:0]      w_dx;
    logic [8:0]      w_dy;
    logic [33:0]     w_head;

    // FLUSH forcing WAIT also masks any capture in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT:  if (!READY_) w_next_state = S_TRACK;
            S_TRACK: if (READY_)  w_next_state = S_WAIT;
            default: w_next_state = S_WAIT;
        endcase
        if (FLUSH) w_next_state = S_WAIT;
    end

    assign w_capture = (w_next_state == S_TRACK) &&
                       (r_first || !CHANGE_ONLY || (Xc != r_prev_x) || (Yc != r_prev_y));

    assign w_dx = r_first ? 9'd0 : ({1'b0, Xc} - {1'b0, r_prev_x});
    assign w_dy = r_first ? 9'd0 : ({1'b0, Yc} - {1'b0, r_prev_y});

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == 5'd0);
    assign w_pop   = !FLUSH && !w_empty && OUT_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_capture && (!w_full || w_pop);
    assign w_drop  = w_capture && w_full && !w_pop;

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            r_state  <= S_WAIT;
            r_first  <= 1'b1;
            r_prev_x <= 8'd0;
            r_prev_y <= 8'd0;
        end else if (FLUSH) begin
            r_state <= S_WAIT;
            r_first <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_TRACK && w_next_state == S_WAIT) begin
                r_first <= 1'b1;
            end else if (w_capture) begin
                r_first <= 1'b0;
            end
            // History follows every capture, even one the FIFO has to drop.
            if (w_capture) begin
                r_prev_x <= Xc;
                r_prev_y <= Yc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= 5'd0;
            r_ovf_cnt <= 8'd0;
        end else if (FLUSH) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= 5'd0;
            r_ovf_cnt <= 8'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {Xc, Yc, w_dx, w_dy};
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign OUT_X       = w_head[33:26];
    assign OUT_Y       = w_head[25:18];
    assign OUT_DX      = w_head[17:9];
    assign OUT_DY      = w_head[8:0];
    assign OUT_VALID   = !w_empty;
    assign COUNT       = r_count;
    assign FULL        = w_full;
    assign EMPTY       = w_empty;
    assign OVF_CNT     = r_ovf_cnt;
    assign o_dbg_state = r_state;

endmodule
